// File: rtl/audio_pkg.sv
// audio_pkg: shared sample/frame widths and the stereo frame packing used by the DAC path.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_W = 32;
  localparam int LEFT_LSB = 16;
  localparam int RIGHT_LSB = 0;
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [FRAME_W-1:0] frame_t;
  function automatic frame_t pack_frame(sample_t l, sample_t r);
    frame_t f;
    f = '0;
    f[LEFT_LSB +: SAMPLE_W] = l;
    f[RIGHT_LSB +: SAMPLE_W] = r;
    return f;
  endfunction
  function automatic sample_t left_of(frame_t f);
    return f[LEFT_LSB +: SAMPLE_W];
  endfunction
  function automatic sample_t right_of(frame_t f);
    return f[RIGHT_LSB +: SAMPLE_W];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head read so pop and consume share a cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic             CLK_18_4,
  input  logic             RST_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge CLK_18_4 or negedge RST_N)
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge CLK_18_4)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/audio_frame_fifo.sv
// audio_frame_fifo: stereo frame buffer feeding the I2S serializer; outputs change only on the
// AUD_LRCK falling edge, with mute and sticky underrun handling.
module audio_frame_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic        CLK_18_4,
  input  logic        RST_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  input  logic        aud_lrck,
  input  logic        mute,
  input  logic        underrun_clr,
  output logic [15:0] left_sample,
  output logic [15:0] right_sample,
  output logic [AW:0] fifo_level,
  output logic        underrun,
  output logic        frame_tick
);
  frame_t head, nxt;
  logic full, empty, lrck_d, lrck_fall, clr_pend;
  assign lrck_fall = lrck_d & ~aud_lrck;
  assign in_ready = ~full;
  sync_fifo #(.WIDTH(FRAME_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .CLK_18_4 (CLK_18_4),
    .RST_N    (RST_N),
    .push     (in_valid & in_ready),
    .pop      (lrck_fall),
    .wdata    (pack_frame(in_left, in_right)),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );
  always_comb
    nxt = (mute || (empty && UNDERRUN_ZERO)) ? '0 : empty ? pack_frame(left_sample, right_sample) : head;
  // a clear request waits for the next boundary; a fresh underrun at that boundary overrides it
  always_ff @(posedge CLK_18_4 or negedge RST_N)
    if (!RST_N) begin
      lrck_d <= 1'b0;
      frame_tick <= 1'b0;
      left_sample <= '0;
      right_sample <= '0;
      underrun <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      lrck_d <= aud_lrck;
      frame_tick <= lrck_fall;
      clr_pend <= lrck_fall ? 1'b0 : clr_pend | underrun_clr;
      if (lrck_fall) begin
        left_sample <= left_of(nxt);
        right_sample <= right_of(nxt);
        underrun <= empty | (underrun & ~(clr_pend | underrun_clr));
      end
    end
endmodule

// File: tb/tb_audio_frame_fifo.sv
// tb_audio_frame_fifo: queue scoreboard for both underrun policies, plus directed full/mute/underrun checks.
module tb_audio_frame_fifo;
  logic CLK_18_4 = 1'b0, RST_N = 1'b1;
  logic in_valid = 1'b0, aud_lrck = 1'b0, mute = 1'b0, underrun_clr = 1'b0;
  logic [15:0] in_left = '0, in_right = '0;
  logic in_ready_a, underrun_a, tick_a, in_ready_b, underrun_b, tick_b;
  logic [15:0] left_a, right_a, left_b, right_b;
  logic [4:0] level_a, level_b;
  int checks = 0, failures = 0, tick_cnt = 0;

  audio_frame_fifo #(.DEPTH(16), .AW(4), .UNDERRUN_ZERO(1'b0)) dut_a (
    .CLK_18_4(CLK_18_4), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_left(in_left), .in_right(in_right), .aud_lrck(aud_lrck), .mute(mute),
    .underrun_clr(underrun_clr), .left_sample(left_a), .right_sample(right_a),
    .fifo_level(level_a), .underrun(underrun_a), .frame_tick(tick_a));
  audio_frame_fifo #(.DEPTH(16), .AW(4), .UNDERRUN_ZERO(1'b1)) dut_b (
    .CLK_18_4(CLK_18_4), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_left(in_left), .in_right(in_right), .aud_lrck(aud_lrck), .mute(mute),
    .underrun_clr(underrun_clr), .left_sample(left_b), .right_sample(right_b),
    .fifo_level(level_b), .underrun(underrun_b), .frame_tick(tick_b));

  always #27 CLK_18_4 = ~CLK_18_4;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_18_4);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_valid = 1'b1;
    in_left = l;
    in_right = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic lr_period(input int hi, input int lo);
    aud_lrck = 1'b1;
    repeat (hi) tick();
    aud_lrck = 1'b0;
    repeat (lo) tick();
  endtask

  // scoreboard: frames queued on accepted pushes, popped on each modelled LRCK falling edge
  logic [31:0] q[$];
  logic [31:0] h;
  logic m_lrck_d, m_tick, m_und, m_clr, fall, pushm;
  logic [15:0] m_la, m_ra, m_lb, m_rb;
  always @(posedge CLK_18_4 or negedge RST_N)
    if (!RST_N) begin
      q.delete();
      m_lrck_d <= 1'b0; m_tick <= 1'b0; m_und <= 1'b0; m_clr <= 1'b0;
      m_la <= '0; m_ra <= '0; m_lb <= '0; m_rb <= '0;
    end else begin
      fall = m_lrck_d & ~aud_lrck;
      pushm = in_valid && q.size() < 16;
      m_lrck_d <= aud_lrck;
      m_tick <= fall;
      m_clr <= fall ? 1'b0 : (m_clr | underrun_clr);
      if (fall && q.size() != 0) begin
        h = q.pop_front();
        m_la <= mute ? 16'h0 : h[31:16];
        m_ra <= mute ? 16'h0 : h[15:0];
        m_lb <= mute ? 16'h0 : h[31:16];
        m_rb <= mute ? 16'h0 : h[15:0];
        m_und <= m_und & ~(m_clr | underrun_clr);
      end else if (fall) begin
        m_und <= 1'b1;
        if (mute) begin m_la <= '0; m_ra <= '0; end
        m_lb <= '0;
        m_rb <= '0;
      end
      if (pushm) q.push_back({in_left, in_right});
    end

  logic [31:0] prev_a = '0;
  always @(negedge CLK_18_4) begin
    check("frame_tick", 32'(tick_a), 32'(m_tick));
    check("frame_tick_b", 32'(tick_b), 32'(m_tick));
    check("fifo_level", 32'(level_a), 32'(q.size()));
    check("in_ready", 32'(in_ready_a), 32'(q.size() != 16));
    check("underrun", 32'(underrun_a), 32'(m_und));
    check("out_hold", {left_a, right_a}, {m_la, m_ra});
    check("out_zero", {left_b, right_b}, {m_lb, m_rb});
    check("stable", 32'(({left_a, right_a} != prev_a) && !tick_a), 32'(0));
    if (tick_a) tick_cnt++;
    prev_a = {left_a, right_a};
  end

  int acc, t0;
  initial begin
    #1 RST_N = 1'b0;
    repeat (3) tick();
    check("rst_left", 32'(left_a), 32'(0));
    check("rst_right", 32'(right_a), 32'(0));
    check("rst_level", 32'(level_a), 32'(0));
    check("rst_ready", 32'(in_ready_a), 32'(1));
    check("rst_underrun", 32'(underrun_a), 32'(0));
    RST_N = 1'b1;
    tick();
    push(16'h0101, 16'h0202);
    push(16'h0303, 16'h0404);
    check("pre_rst_level", 32'(level_a), 32'(2));
    RST_N = 1'b0;
    tick();
    check("mid_rst_level", 32'(level_a), 32'(0));
    RST_N = 1'b1;
    tick();
    // idle at 48 kHz: 384-clock LRCK period
    t0 = tick_cnt;
    repeat (3) lr_period(192, 192);
    check("idle_ticks", 32'(tick_cnt - t0), 32'(3));
    check("idle_underrun", 32'(underrun_a), 32'(1));
    check("idle_out", {left_a, right_a}, 32'(0));
    check("idle_ready", 32'(in_ready_a), 32'(1));
    // ordering
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    push(16'h1111, 16'hAAAA);
    push(16'h2222, 16'hBBBB);
    push(16'h7FFF, 16'h8000);
    check("ord_level3", 32'(level_a), 32'(3));
    check("ord_und_pending", 32'(underrun_a), 32'(1));
    lr_period(4, 4);
    check("ord_level2", 32'(level_a), 32'(2));
    check("ord_und_clr", 32'(underrun_a), 32'(0));
    check("ord_f1", {left_a, right_a}, 32'h1111AAAA);
    lr_period(4, 4);
    check("ord_level1", 32'(level_a), 32'(1));
    check("ord_f2", {left_a, right_a}, 32'h2222BBBB);
    lr_period(4, 4);
    check("ord_level0", 32'(level_a), 32'(0));
    check("ord_f3", {left_a, right_a}, 32'h7FFF8000);
    // full: no boundaries while in_valid is held
    aud_lrck = 1'b1;
    tick();
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      in_left = 16'h3000 + 16'(i);
      in_right = 16'h4000 + 16'(i);
      if (in_ready_a) acc++;
      tick();
    end
    check("full_accepted", 32'(acc), 32'(16));
    check("full_level", 32'(level_a), 32'(16));
    check("full_ready", 32'(in_ready_a), 32'(0));
    in_left = 16'h7FFF;
    in_right = 16'h8000;
    aud_lrck = 1'b0;
    tick();
    check("full_pop_ready", 32'(in_ready_a), 32'(1));
    check("full_pop_level", 32'(level_a), 32'(15));
    tick();
    in_valid = 1'b0;
    check("full_17th", 32'(level_a), 32'(16));
    // underrun policy
    repeat (16) lr_period(2, 2);
    check("drain_level", 32'(level_a), 32'(0));
    check("drain_last", {left_a, right_a}, 32'h7FFF8000);
    repeat (2) lr_period(2, 2);
    check("ur_hold", {left_a, right_a}, 32'h7FFF8000);
    check("ur_zero", {left_b, right_b}, 32'(0));
    check("ur_flag", 32'(underrun_a), 32'(1));
    check("ur_flag_b", 32'(underrun_b), 32'(1));
    push(16'h5555, 16'h6666);
    push(16'h5656, 16'h6767);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("clr_wait", 32'(underrun_a), 32'(1));
    lr_period(2, 2);
    check("clr_done", 32'(underrun_a), 32'(0));
    // mute with four frames queued
    push(16'h0A0A, 16'h0B0B);
    push(16'h0C0C, 16'h0D0D);
    push(16'h0E0E, 16'h0F0F);
    mute = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lr_period(2, 2);
      check("mute_level", 32'(level_a), 32'(3 - i));
      check("mute_out", {left_a, right_a}, 32'(0));
    end
    mute = 1'b0;
    // push coincident with a boundary, half full
    for (int i = 0; i < 8; i++) push(16'h9000 + 16'(i), 16'hA000 + 16'(i));
    aud_lrck = 1'b1;
    repeat (2) tick();
    aud_lrck = 1'b0;
    in_valid = 1'b1;
    in_left = 16'h1234;
    in_right = 16'h5678;
    tick();
    in_valid = 1'b0;
    check("simul_level", 32'(level_a), 32'(8));
    check("simul_out", {left_a, right_a}, 32'h9000A000);
    // random traffic; the negedge monitor checks every cycle
    for (int i = 0; i < 4000; i++) begin
      in_valid = 1'($urandom_range(0, 2) == 0);
      in_left = 16'($urandom);
      in_right = 16'($urandom);
      if ($urandom_range(0, 11) == 0) aud_lrck = ~aud_lrck;
      mute = 1'($urandom_range(0, 19) == 0);
      underrun_clr = 1'($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0;
    mute = 1'b0;
    underrun_clr = 1'b0;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
